// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the FSM state encoding and the leading-zero digit-mask helper.
package seg_arb_pkg;

  typedef enum logic [1:0] {ARB, GRANT, HOLD} seg_arb_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int VAL_W      = NUM_DIGITS * DIGIT_W;

  // Digit i is lit when it or any more significant digit is non-zero; digit 0 always lit.
  function automatic logic [NUM_DIGITS-1:0] digit_mask(input logic [VAL_W-1:0] val);
    logic [NUM_DIGITS-1:0] en;
    logic                  seen;
    seen = 1'b0;
    en   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen  = seen | (val[i*DIGIT_W +: DIGIT_W] != '0);
      en[i] = seen;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester handshake plus display-side outputs of the seven-segment arbiter.
// master = requesters/display consumer, slave = arbiter.
interface seg_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import seg_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ-1:0][VAL_W-1:0] req_val_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic [VAL_W-1:0]              val_out;
  logic [IDX_W-1:0]              owner_out;
  logic                          active_out;
  logic [NUM_DIGITS-1:0]         dig_en_out;

  modport master (
    output req_valid_in,
    output req_val_in,
    input  req_ready_out,
    input  val_out,
    input  owner_out,
    input  active_out,
    input  dig_en_out
  );

  modport slave (
    input  req_valid_in,
    input  req_val_in,
    output req_ready_out,
    output val_out,
    output owner_out,
    output active_out,
    output dig_en_out
  );

endinterface

// File: rtl/seg_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping from NUM_REQ-1 back to 0.
module seg_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit display; each accepted value is held >= HOLD_CYCLES.
// Optional SEG_ARB_BLANK_LEADING_ZEROS_EN: dig_en_out blanks leading zero digits.
//
// state | meaning
// ARB   | waiting for any valid request; display keeps last value
// GRANT | ready pulsed to winner; transfer if winner still valid
// HOLD  | counting down the minimum display time; requests ignored
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  seg_display_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  seg_arb_state_t        state_q;
  logic [IDX_W-1:0]      winner_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    ready_q;
  logic [VAL_W-1:0]      val_q;
  logic [IDX_W-1:0]      owner_q;
  logic                  active_q;
  logic [NUM_DIGITS-1:0] dig_en_q;

  logic [IDX_W-1:0]      pick;
  logic                  any_valid;
  logic [NUM_REQ-1:0]    grant_onehot_d;
  logic [IDX_W-1:0]      ptr_d;
  logic [VAL_W-1:0]      val_d;
  logic [NUM_DIGITS-1:0] dig_en_d;

  seg_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (bus.req_valid_in),
    .ptr_i    (ptr_q),
    .winner_o (pick),
    .any_o    (any_valid)
  );

  assign grant_onehot_d = NUM_REQ'(1) << pick;
  assign ptr_d          = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
  assign val_d          = bus.req_val_in[winner_q];

`ifdef SEG_ARB_BLANK_LEADING_ZEROS_EN
  assign dig_en_d = digit_mask(val_d);
`else
  assign dig_en_d = '1;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ARB;
      winner_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= '0;
      val_q    <= '0;
      owner_q  <= '0;
      active_q <= 1'b0;
      dig_en_q <= '1;
    end else begin
      ready_q <= '0;
      case (state_q)
        ARB: begin
          if (any_valid) begin
            winner_q <= pick;
            ready_q  <= grant_onehot_d;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          // A requester that let valid fall before the accept edge loses its turn.
          if (bus.req_valid_in[winner_q]) begin
            val_q    <= val_d;
            owner_q  <= winner_q;
            dig_en_q <= dig_en_d;
            active_q <= 1'b1;
            ptr_q    <= ptr_d;
            cnt_q    <= HOLD_LOAD;
            state_q  <= HOLD;
          end else begin
            state_q <= ARB;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ARB;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.req_ready_out = ready_q;
  assign bus.val_out       = val_q;
  assign bus.owner_out     = owner_q;
  assign bus.active_out    = active_q;
  assign bus.dig_en_out    = dig_en_q;

endmodule
